// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master bridging a req/gnt core port to APB,
// with an optional PREADY timeout that completes the transfer with err_o.
module apb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          done, abort;
  assign done  = (state == ACCESS) && PREADY;
  // abort fires in the ACCESS cycle whose stall would bring the counter to the limit
  assign abort = (TIMEOUT_CYCLES > 0) && (state == ACCESS) && !PREADY && (wait_cnt == LAST);
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  always_comb begin
    state_nxt = (state == IDLE)  ? (req_i ? SETUP : IDLE) :
                (state == SETUP) ? ACCESS :
                (done || abort)  ? IDLE : ACCESS;
  end
  always_comb begin
    gnt_o   = req_i && (state == IDLE);
    PSEL    = (state != IDLE);
    PENABLE = (state == ACCESS);
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      PADDR  <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
    end else if (gnt_o) begin
      PADDR  <= addr_i;
      PWDATA <= we_i ? wdata_i : 32'h0;
      PWRITE <= we_i;
    end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn)                                        wait_cnt <= '0;
    else if (gnt_o)                                      wait_cnt <= '0;
    else if (state == ACCESS && !PREADY && wait_cnt != SAT) wait_cnt <= wait_cnt + 1'b1;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= done || abort;
      err_o    <= abort;
      if (done || abort) rdata_o <= (done && !PWRITE) ? PRDATA : 32'h0;
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table vectors, hand sequences and random transfers for apb_master.
module tb_apb_master;
  localparam int T = 16;
  logic        PCLK = 1'b0, PRESETn = 1'b0, req_i = 1'b0, we_i = 1'b0, PREADY = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0, PRDATA = '0;
  logic        gnt_o, rvalid_o, err_o, PWRITE, PSEL, PENABLE;
  logic [31:0] rdata_o, PADDR, PWDATA;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] last_rdata = '0;

  apb_master #(.TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, prdata;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a transfer stalled for T or more cycles times out after T ACCESS cycles
  function automatic void model(input logic we, input logic [31:0] prdata, input int waits,
                                output logic err, output logic [31:0] rdata, output int lat);
    err   = (T > 0) && (waits >= T);
    rdata = (err || we) ? 32'h0 : prdata;
    lat   = err ? T + 2 : waits + 3;
  endfunction

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] prdata, input int waits, input logic e_err,
                      input logic [31:0] e_rdata, input int e_lat, input string tag);
    int c;
    logic [31:0] pw;
    pw = we ? wdata : 32'h0;
    @(negedge PCLK);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; PREADY = 1'b1; PRDATA = $urandom;
    #1;
    chk({tag, " gnt"}, gnt_o, 1);
    chk({tag, " idle psel"}, PSEL, 0);
    @(negedge PCLK);
    req_i = 1'b0; we_i = ~we; addr_i = $urandom; wdata_i = $urandom; PREADY = 1'b1; PRDATA = $urandom;
    #1;
    chk({tag, " setup psel"}, PSEL, 1);
    chk({tag, " setup penable"}, PENABLE, 0);
    chk({tag, " setup paddr"}, PADDR, addr);
    chk({tag, " setup pwrite"}, PWRITE, we);
    chk({tag, " setup pwdata"}, PWDATA, pw);
    chk({tag, " rdata hold"}, rdata_o, last_rdata);
    c = 1;
    for (int k = 1; k <= T; k++) begin
      @(negedge PCLK);
      c++;
      PREADY = (k == waits + 1);
      PRDATA = PREADY ? prdata : $urandom;
      #1;
      chk({tag, " access psel"}, PSEL, 1);
      chk({tag, " access penable"}, PENABLE, 1);
      chk({tag, " access paddr"}, PADDR, addr);
      chk({tag, " access pwrite"}, PWRITE, we);
      chk({tag, " access pwdata"}, PWDATA, pw);
      chk({tag, " access rvalid"}, rvalid_o, 0);
      if (PREADY) break;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      c++;
      PREADY = 1'b0; PRDATA = $urandom;
      #1;
      if (rvalid_o) break;
    end
    chk({tag, " rvalid"}, rvalid_o, 1);
    chk({tag, " latency"}, c, e_lat);
    chk({tag, " err"}, err_o, e_err);
    chk({tag, " rdata"}, rdata_o, e_rdata);
    chk({tag, " done psel"}, PSEL, 0);
    chk({tag, " done penable"}, PENABLE, 0);
    last_rdata = e_rdata;
    @(negedge PCLK);
    #1;
    chk({tag, " rvalid pulse"}, rvalid_o, 0);
    chk({tag, " err pulse"}, err_o, 0);
    chk({tag, " rdata held"}, rdata_o, e_rdata);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    logic        we, e_err;
    logic [31:0] addr, wdata, prdata, e_rdata;
    int          w, e_lat;
    vecs[0] = '{1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, 0,  1'b0, 32'h1234_5678, 3};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 3,  1'b0, 32'h0,         6};
    vecs[2] = '{1'b0, 32'h0000_1003, 32'h0,         32'hCAFE_F00D, 15, 1'b0, 32'hCAFE_F00D, 18};
    vecs[3] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1111_1111, 16, 1'b1, 32'h0,         18};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h2222_2222, 1,  1'b0, 32'h0,         4};
    vecs[5] = '{1'b0, 32'h0000_0007, 32'h0,         32'hFFFF_FFFF, 2,  1'b0, 32'hFFFF_FFFF, 5};
    vecs[6] = '{1'b1, 32'h0000_0040, 32'h1357_9BDF, 32'h3333_3333, 30, 1'b1, 32'h0,         18};
    #1;
    chk("reset psel", PSEL, 0);
    chk("reset penable", PENABLE, 0);
    chk("reset pwrite", PWRITE, 0);
    chk("reset paddr", PADDR, 0);
    chk("reset pwdata", PWDATA, 0);
    chk("reset rvalid", rvalid_o, 0);
    chk("reset err", err_o, 0);
    chk("reset rdata", rdata_o, 0);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    chk("idle gnt no req", gnt_o, 0);

    foreach (vecs[i])
      xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].prdata, vecs[i].waits,
           vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat, $sformatf("vec%0d", i));

    // Back-to-back writes with req_i held: one transfer every three cycles
    for (int c = 0; c < 10; c++) begin
      @(negedge PCLK);
      req_i = (c < 7); we_i = 1'b1; PREADY = 1'b1; PRDATA = $urandom;
      addr_i = 32'h100 + 32'(c / 3) * 4; wdata_i = 32'hB000_0000 + 32'(c / 3);
      #1;
      chk($sformatf("b2b gnt c%0d", c), gnt_o, (c == 0 || c == 3 || c == 6));
      chk($sformatf("b2b psel c%0d", c), PSEL, (c % 3 != 0 && c < 9));
      chk($sformatf("b2b penable c%0d", c), PENABLE, (c % 3 == 2 && c < 9));
      chk($sformatf("b2b rvalid c%0d", c), rvalid_o, (c % 3 == 0 && c > 0));
      if (c % 3 == 1) begin
        chk($sformatf("b2b paddr c%0d", c), PADDR, 32'h100 + 32'(c / 3) * 4);
        chk($sformatf("b2b pwdata c%0d", c), PWDATA, 32'hB000_0000 + 32'(c / 3));
      end
      if (c % 3 == 0 && c > 0) chk($sformatf("b2b rdata c%0d", c), rdata_o, 0);
    end
    last_rdata = 32'h0;

    // Reset in the middle of an ACCESS stall aborts silently
    @(negedge PCLK);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h55; wdata_i = 32'h77; PREADY = 1'b0;
    @(negedge PCLK);
    req_i = 1'b0;
    repeat (2) @(negedge PCLK);
    #1;
    chk("rst pre penable", PENABLE, 1);
    PRESETn = 1'b0;
    #1;
    chk("rst psel", PSEL, 0);
    chk("rst penable", PENABLE, 0);
    chk("rst paddr", PADDR, 0);
    chk("rst pwdata", PWDATA, 0);
    chk("rst pwrite", PWRITE, 0);
    chk("rst rvalid", rvalid_o, 0);
    @(negedge PCLK);
    PRESETn = 1'b1; PREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      #1;
      chk($sformatf("post rst rvalid %0d", i), rvalid_o, 0);
      chk($sformatf("post rst psel %0d", i), PSEL, 0);
    end
    xfer(1'b0, 32'h0000_0ABC, 32'h0, 32'h600D_CAFE, 1, 1'b0, 32'h600D_CAFE, 4, "post rst");

    for (int i = 0; i < 40; i++) begin
      we     = 1'($urandom_range(1));
      addr   = $urandom;
      wdata  = $urandom;
      prdata = $urandom;
      w      = ($urandom_range(3) == 0) ? 13 + int'($urandom_range(5)) : int'($urandom_range(4));
      model(we, prdata, w, e_err, e_rdata, e_lat);
      xfer(we, addr, wdata, prdata, w, e_err, e_rdata, e_lat, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
